// File: rtl/im_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The VERIFY state exists only when IM_LOADER_VERIFY_EN is defined.
package im_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF  = 8'hA5;
  localparam int         LEN_W          = 16;
  localparam int         BYTES_PER_WORD = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA_LO,
    ST_DATA_HI,
    ST_CSUM,
`ifdef IM_LOADER_VERIFY_EN
    ST_VERIFY,
`endif
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/im_loader_timeout.sv
// Inter-byte watchdog: 'load' rearms the count, 'clear' disarms it, and
// 'expired' is raised once an armed count has run down to zero.
module im_loader_timeout #(
  parameter int CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic clear,
  output logic expired
);

  localparam int CW = $clog2(CYCLES);

  logic [CW-1:0] count;
  logic          armed;

  // A load has priority so the byte that starts a frame also arms the timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      armed <= 1'b0;
    end else if (load) begin
      count <= CW'(CYCLES - 1);
      armed <= 1'b1;
    end else if (clear) begin
      armed <= 1'b0;
    end else if (armed && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = armed && (count == '0);

endmodule

// File: rtl/im_loader.sv
// Boot loader: parses SYNC/LEN/data/CSUM frames from the UART and writes the
// instruction memory. Define IM_LOADER_VERIFY_EN to add a read-back check.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int          ADDR_W         = 12,
  parameter int          DATA_W         = 16,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_wre,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int               WORD_W  = BYTES_PER_WORD * 8;
  localparam logic [LEN_W:0]   MAX_LEN = (LEN_W + 1)'(2 ** ADDR_W);

  state_t            state;
  logic [7:0]        len_lo;
  logic [7:0]        lo_byte;
  logic [7:0]        csum;
  logic [ADDR_W:0]   word_idx;
  logic [ADDR_W:0]   n_words;
  logic [LEN_W-1:0]  len_next;
  logic              len_bad;
  logic [ADDR_W:0]   idx_next;
  logic [WORD_W-1:0] word_asm;
  logic              active;
  logic              tmo_expired;

  always_comb begin
    len_next = {rx_data, len_lo};
    len_bad  = (len_next == '0) || ({1'b0, len_next} > MAX_LEN);
    idx_next = word_idx + 1'b1;
    word_asm = {rx_data, lo_byte};
    active   = state inside {ST_LEN_LO, ST_LEN_HI, ST_DATA_LO, ST_DATA_HI, ST_CSUM};
  end

  im_loader_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .load    (rx_valid),
    .clear   (!active),
    .expired (tmo_expired)
  );

`ifdef IM_LOADER_VERIFY_EN
  logic [ADDR_W:0] rd_idx;
  logic [ADDR_W:0] smp_cnt;
  logic [7:0]      vsum;
  logic [7:0]      vsum_next;
  logic            rd_pend;

  always_comb begin
    vsum_next = vsum + ram_dout[7:0] + ram_dout[15:8];
  end
`else
  logic unused_dout;
  assign unused_dout = ^ram_dout;
  assign ram_oce     = 1'b0;
`endif

  // Single FSM; RAM strobes default low every cycle and are raised for one clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      ram_ce   <= 1'b0;
      ram_wre  <= 1'b0;
      ram_ad   <= '0;
      ram_din  <= '0;
      cpu_hold <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      len_lo   <= '0;
      lo_byte  <= '0;
      csum     <= '0;
      word_idx <= '0;
      n_words  <= '0;
`ifdef IM_LOADER_VERIFY_EN
      ram_oce  <= 1'b0;
      rd_idx   <= '0;
      smp_cnt  <= '0;
      vsum     <= '0;
      rd_pend  <= 1'b0;
`endif
    end else begin
      ram_ce  <= 1'b0;
      ram_wre <= 1'b0;
`ifdef IM_LOADER_VERIFY_EN
      ram_oce <= 1'b0;
      rd_pend <= ram_ce && ram_oce;
`endif
      unique case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (state == ST_DONE) begin
            done     <= 1'b1;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
          end else if (state == ST_ERR) begin
            error    <= 1'b1;
            busy     <= 1'b0;
            cpu_hold <= 1'b1;
          end
          state <= ST_IDLE;
          if (rx_valid && rx_data == SYNC_BYTE) begin
            state    <= ST_LEN_LO;
            busy     <= 1'b1;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
          end
        end
`ifdef IM_LOADER_VERIFY_EN
        // Reads are issued one per clock; data returns two edges after issue.
        ST_VERIFY: begin
          if (rd_idx != n_words) begin
            ram_ce  <= 1'b1;
            ram_oce <= 1'b1;
            ram_ad  <= rd_idx[ADDR_W-1:0];
            rd_idx  <= rd_idx + 1'b1;
          end
          if (rd_pend) begin
            vsum    <= vsum_next;
            smp_cnt <= smp_cnt + 1'b1;
            if (smp_cnt + 1'b1 == n_words)
              state <= (vsum_next == csum) ? ST_DONE : ST_ERR;
          end
        end
`endif
        default: begin
          if (rx_valid) begin
            case (state)
              ST_LEN_LO: begin
                len_lo <= rx_data;
                state  <= ST_LEN_HI;
              end
              ST_LEN_HI: begin
                if (len_bad) begin
                  state <= ST_ERR;
                end else begin
                  n_words  <= len_next[ADDR_W:0];
                  word_idx <= '0;
                  csum     <= '0;
                  state    <= ST_DATA_LO;
                end
              end
              ST_DATA_LO: begin
                lo_byte <= rx_data;
                csum    <= csum + rx_data;
                state   <= ST_DATA_HI;
              end
              ST_DATA_HI: begin
                csum     <= csum + rx_data;
                ram_ce   <= 1'b1;
                ram_wre  <= 1'b1;
                ram_ad   <= word_idx[ADDR_W-1:0];
                ram_din  <= DATA_W'(word_asm);
                word_idx <= idx_next;
                state    <= (idx_next == n_words) ? ST_CSUM : ST_DATA_LO;
              end
              ST_CSUM: begin
                if (rx_data != csum) begin
                  state <= ST_ERR;
                end else begin
`ifdef IM_LOADER_VERIFY_EN
                  state   <= ST_VERIFY;
                  ram_ce  <= 1'b1;
                  ram_oce <= 1'b1;
                  ram_ad  <= '0;
                  rd_idx  <= {{ADDR_W{1'b0}}, 1'b1};
                  smp_cnt <= '0;
                  vsum    <= '0;
`else
                  state <= ST_DONE;
`endif
                end
              end
              default: ;
            endcase
          end else if (tmo_expired) begin
            state <= ST_ERR;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Scoreboarded bench for im_loader: expected RAM writes are queued by the
// stimulus and popped by a monitor that watches the IM port.
module tb_im_loader;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int TMO    = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              ram_ce, ram_oce, ram_wre;
  logic [ADDR_W-1:0] ram_ad;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout = '0;
  logic              cpu_hold, busy, done, error;

  logic [15:0] mem [0:4095];
  logic        corrupt = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int oce_cnt = 0;

  logic [27:0] exp_wr [$];
  int          exp_cyc [$];

  always #5 clk = ~clk;

  im_loader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre), .ram_ad(ram_ad),
    .ram_din(ram_din), .ram_dout(ram_dout), .cpu_hold(cpu_hold), .busy(busy),
    .done(done), .error(error)
  );

  // Synchronous IM model; word 1 can be corrupted on read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_ce) begin
      if (ram_wre) mem[ram_ad] <= ram_din;
      else if (ram_oce) ram_dout <= mem[ram_ad] ^ ((corrupt && ram_ad == 12'd1) ? 16'h0100 : 16'h0000);
    end
  end

  // Monitor: every write strobe must match the next queued write and cycle.
  always @(negedge clk) begin
    logic [27:0] e;
    int          c;
    if (ram_ce && ram_oce) oce_cnt++;
    if (ram_ce && ram_wre) begin
      checks++;
      if (exp_wr.size() == 0) begin
        failures++;
        $display("[TB] FAIL write_unexpected: got ad=%h din=%h, required no write", ram_ad, ram_din);
      end else begin
        e = exp_wr.pop_front();
        c = (exp_cyc.size() != 0) ? exp_cyc.pop_front() : -1;
        if ({ram_ad, ram_din} !== e) begin
          failures++;
          $display("[TB] FAIL write_data: got ad=%h din=%h, required ad=%h din=%h", ram_ad, ram_din, e[27:16], e[15:0]);
        end
        checks++;
        if (c != cyc) begin
          failures++;
          $display("[TB] FAIL write_timing: got cycle %0d, required cycle %0d", cyc, c);
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, required);
    end
  endtask

  task automatic expect_write(input logic [11:0] ad, input logic [15:0] din);
    exp_wr.push_back({ad, din});
  endtask

  task automatic send_byte(input logic [7:0] b, input bit hi);
    @(negedge clk);
    if (hi) exp_cyc.push_back(cyc + 1);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  // Bytes are listed MSB-first in 'bytes'; s is the position of the sync byte.
  task automatic apply_stimulus(input logic [127:0] bytes, input int n, input int s);
    logic [7:0] b;
    logic [7:0] lo;
    int         nw;
    bit         hi;
    nw = 0;
    lo = 8'h00;
    for (int i = 0; i < n; i++) begin
      b = bytes[8*(n-1-i) +: 8];
      if (i == s + 1) lo = b;
      if (i == s + 2) nw = int'({b, lo});
      hi = (i >= s + 3) && (((i - s - 3) % 2) == 1) && ((i - s - 3) < 2 * nw);
      send_byte(b, hi);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic finish_frame();
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 6000 && !idle; k++) begin
      @(negedge clk);
      idle = !busy;
    end
    check_output("busy_settle", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check_output("pending_writes", exp_wr.size(), 32'd0);
    exp_wr.delete();
    exp_cyc.delete();
  endtask

  task automatic check_status(input string tag, input bit d, input bit e, input bit h);
    check_output({tag, "_done"}, {31'd0, done}, {31'd0, d});
    check_output({tag, "_error"}, {31'd0, error}, {31'd0, e});
    check_output({tag, "_hold"}, {31'd0, cpu_hold}, {31'd0, h});
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_ram"}, {ram_ce, ram_oce, ram_wre, ram_ad, ram_din}, 32'd0);
    check_output({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_status(tag, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;

    $display("[TB] good two-word frame");
    expect_write(12'd0, 16'h1234);
    expect_write(12'd1, 16'h5678);
    apply_stimulus(128'hA5_02_00_34_12_78_56_14, 8, 0);
    finish_frame();
    check_status("good", 1'b1, 1'b0, 1'b0);

    $display("[TB] zero length");
    apply_stimulus(128'hA5_00_00, 3, 0);
    finish_frame();
    check_status("len0", 1'b0, 1'b1, 1'b1);

    $display("[TB] leading junk, back-to-back N=1");
    expect_write(12'd0, 16'hABCD);
    apply_stimulus(128'h00_FF_A5_01_00_CD_AB_78, 8, 2);
    finish_frame();
    check_status("junk", 1'b1, 1'b0, 1'b0);

    $display("[TB] length 4097");
    apply_stimulus(128'hA5_01_10, 3, 0);
    finish_frame();
    check_status("len4097", 1'b0, 1'b1, 1'b1);
    apply_stimulus(128'h00, 1, -10);
    repeat (2) @(negedge clk);
    check_output("error_sticky", {31'd0, error}, 32'd1);

    $display("[TB] reset mid-frame");
    apply_stimulus(128'hA5_04_00_11, 4, 0);
    check_output("busy_midframe", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check_reset_values("midreset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) expect_write(12'(i), 16'(i + 1));
    apply_stimulus(128'hA5_04_00_01_00_02_00_03_00_04_00_0A, 12, 0);
    finish_frame();
    check_status("after_reset", 1'b1, 1'b0, 1'b0);

    $display("[TB] bad checksum");
    expect_write(12'd0, 16'h1234);
    expect_write(12'd1, 16'h5678);
    apply_stimulus(128'hA5_02_00_34_12_78_56_15, 8, 0);
    finish_frame();
    check_status("badsum", 1'b0, 1'b1, 1'b1);

    $display("[TB] full depth N=4096");
    for (int i = 0; i < 4096; i++) expect_write(12'(i), 16'h0000);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    for (int i = 0; i < 8192; i++) send_byte(8'h00, (i % 2) == 1);
    send_byte(8'h00, 1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    finish_frame();
    check_status("n4096", 1'b1, 1'b0, 1'b0);

    $display("[TB] inter-byte timeout");
    apply_stimulus(128'hA5_02_00_34, 4, 0);
    repeat (2 * TMO) @(negedge clk);
    check_output("timeout_busy", {31'd0, busy}, 32'd0);
    check_status("timeout", 1'b0, 1'b1, 1'b1);
    check_output("timeout_pending", exp_wr.size(), 32'd0);

`ifdef IM_LOADER_VERIFY_EN
    $display("[TB] verify with corrupted read-back");
    corrupt = 1'b1;
    oce_cnt = 0;
    expect_write(12'd0, 16'h1234);
    expect_write(12'd1, 16'h5678);
    apply_stimulus(128'hA5_02_00_34_12_78_56_14, 8, 0);
    finish_frame();
    check_output("verify_reads_bad", oce_cnt, 32'd2);
    check_status("verify_bad", 1'b0, 1'b1, 1'b1);

    $display("[TB] verify with clean read-back");
    corrupt = 1'b0;
    oce_cnt = 0;
    expect_write(12'd0, 16'h1234);
    expect_write(12'd1, 16'h5678);
    apply_stimulus(128'hA5_02_00_34_12_78_56_14, 8, 0);
    finish_frame();
    check_output("verify_reads_ok", oce_cnt, 32'd2);
    check_status("verify_ok", 1'b1, 1'b0, 1'b0);
`else
    check_output("oce_never", oce_cnt, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/im_loader.md
Name: im_loader

Overview:
- Boot-time loader that sits directly upstream of the 4096x16 single-port instruction memory (IM).
- Accepts a framed byte stream from the UART receiver and assembles little-endian 16-bit words.
- Writes the words sequentially into the IM through its ce/oce/wre/ad/din port, checks a frame checksum, and holds the core in reset until the load succeeds.

Parameters:
- ADDR_W, 12, IM address width; depth is 2**ADDR_W words.
- DATA_W, 16, IM word width; fixed at 2 bytes per word.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 1_000_000, maximum idle clocks between bytes inside a frame.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid; may be back-to-back every cycle.
- ram_ce  out  1  IM clock enable.
- ram_oce  out  1  IM output clock enable.
- ram_wre  out  1  IM write enable.
- ram_ad  out  ADDR_W  IM word address.
- ram_din  out  DATA_W  IM write data.
- ram_dout  in  DATA_W  IM read data; used only with the optional feature.
- cpu_hold  out  1  high keeps the core in reset.
- busy  out  1  a frame is in progress.
- done  out  1  sticky; last frame loaded OK.
- error  out  1  sticky; last frame failed.

Behaviour:
- Reset values:
  - All ram_* outputs are 0.
  - cpu_hold=1, busy=0, done=0, error=0.
  - The FSM is in IDLE.
  - Reset at any point, including mid-frame, returns to these values immediately. IM contents are left as they are.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, then 2*N data bytes (low byte first per word), then CSUM. CSUM is the 8-bit modulo-256 sum of all data bytes.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM, (VERIFY), DONE, ERR.
- IDLE:
  - A byte equal to SYNC_BYTE goes to LEN_LO, sets busy=1 and cpu_hold=1, and clears done and error.
  - Any other byte is ignored.
- LEN_LO / LEN_HI:
  - Latch N = {LEN_HI, LEN_LO}.
  - If N==0 or N>2**ADDR_W, go to ERR. N==4096 is legal.
  - Otherwise go to DATA_LO with the word index at 0 and the checksum at 0.
- DATA_LO: latch the low byte, add it to the checksum, go to DATA_HI.
- DATA_HI:
  - Add the high byte to the checksum.
  - Next cycle (registered) pulse ram_ce=1, ram_wre=1, ram_oce=0 for exactly one clock, with ram_ad=index and ram_din={hi,lo}.
  - Increment the index. When the index reaches N, go to CSUM; otherwise go to DATA_LO.
  - Write latency is 1 clock after the hi byte strobe, so back-to-back bytes need no stall.
- CSUM: byte == accumulated sum → DONE (or VERIFY when the optional feature is enabled); otherwise → ERR.
- DONE: busy=0, done=1, cpu_hold=0. Return to IDLE-monitoring on the next cycle; done persists until the next SYNC_BYTE.
- ERR: busy=0, error=1, cpu_hold=1. Return to IDLE-monitoring; error persists until the next SYNC_BYTE.
- Timeout: in any state other than IDLE/DONE/ERR/VERIFY, a counter resets on each rx_valid. Reaching TIMEOUT_CYCLES goes to ERR.
- When not writing, ram_ce=0 and ram_wre=0. ram_ad/ram_din hold their last value.

Optional Feature:
- Macro IM_LOADER_VERIFY_EN.
- Defined:
  - After a good CSUM, enter VERIFY.
  - Issue reads at addresses 0..N-1, one per clock, with ram_ce=1, ram_oce=1, ram_wre=0.
  - ram_dout is valid 1 clock after each address. Accumulate the byte-sum of the read-back words (low byte + high byte).
  - After the last word is sampled, sum == CSUM → DONE, else → ERR. VERIFY takes N+1 clocks.
  - rx_valid is ignored during VERIFY.
- Undefined: no VERIFY state, ram_oce is tied to 0, and ram_dout is unused.

Decomposition:
- Package im_loader_pkg holds:
  - the state enum;
  - SYNC_BYTE default;
  - LEN field width (16);
  - bytes-per-word constant (2).
- One natural sub-module, im_loader_timeout: a loadable down-counter with clear and expire outputs. The FSM, word assembly and checksum stay in the top.

Test Plan:
- Frame A5 02 00 34 12 78 56 14 → writes ad=0 din=16'h1234 and ad=1 din=16'h5678, each a 1-cycle ram_wre pulse 1 clk after its hi byte; done=1, cpu_hold=0, error=0.
- Same frame with CSUM 0x15 → no change to the two writes; error=1, done=0, cpu_hold=1.
- Length 00 00, and separately length 01 10 (N=4097) → ERR immediately after LEN_HI, no RAM write.
- Bytes 00 FF A5 … then a valid N=1 frame sent with back-to-back rx_valid every clock → leading junk ignored, single write at ad=0, done=1.
- Reset asserted after the first data byte of an N=4 frame → all outputs at reset values in the same cycle; a subsequent full valid frame loads correctly.
- With IM_LOADER_VERIFY_EN and a RAM model that corrupts word 1 → VERIFY takes N+1 clocks with oce=1 and ends in error=1. Without the corruption it ends in done=1.
- Stall 2*TIMEOUT_CYCLES (set TIMEOUT_CYCLES=16 in the bench) mid-data → error=1, busy=0.
